mixer_sequencer: RTL and testbench
==================================

Name: mixer_sequencer

Overview:
Time-multiplexed N-channel audio mixer controller in the bclk domain. On each rising lrclk edge it snapshots all channel samples and gain/mute settings, then sequences one multiply-accumulate per bclk cycle through a single shared MAC datapath. It scales and saturates the result and presents one mixed sample with a valid strobe. It replaces per-pair fixed 0.5/0.5 mixers with a runtime-configurable gain per channel.

Parameters:
BITSIZE, 16, sample width (signed two's complement)
CHANNELS, 4, number of input channels (2..16)
GAINBITS, 8, per-channel gain width, unsigned Q1.(GAINBITS-1); 2^(GAINBITS-1) = unity

Ports:
bclk  in  1  bit clock, 64x lrclk, sole clock
resetn  in  1  synchronous active-low reset
lrclk  in  1  frame clock, synchronous to bclk, sampled on bclk
in_bus  in  CHANNELS*BITSIZE  channel samples, channel k at bits [k*BITSIZE +: BITSIZE], signed
cfg_we  in  1  config write strobe
cfg_addr  in  clog2(CHANNELS)  channel index
cfg_gain  in  GAINBITS  gain value to write
cfg_mute  in  1  mute value to write
out  out  BITSIZE  mixed sample, signed
out_valid  out  1  one-cycle strobe, out updated
busy  out  1  high while in ACC or OUT
overrun  out  1  one-cycle pulse, lrclk edge arrived while busy

Behaviour:
- One clock (bclk); reset is synchronous, active-low (resetn).
- Reset values:
  - out=0, out_valid=0, busy=0, overrun=0, state=IDLE.
  - All gains = 2^(GAINBITS-2) (0.5). All mutes = 0.
  - lrclk_d = 1, so reset released while lrclk is high is not an edge.
- Edge detect: edge = lrclk & ~lrclk_d. lrclk_d is registered every cycle.
- States: IDLE, ACC, OUT.
- IDLE, on edge (cycle E):
  - Latch in_bus into sample regs.
  - Copy live gain/mute regs into working regs.
  - acc=0, ch=0, go to ACC.
- ACC (cycles E+1 .. E+CHANNELS):
  - acc += muted[ch] ? 0 : sample[ch]*gain[ch]. Signed x unsigned, gain zero-extended.
  - ch++. After ch==CHANNELS-1, go to OUT.
- OUT (cycle E+CHANNELS+1):
  - out <= clamp(acc >>> (GAINBITS-1)). Arithmetic shift, floor rounding.
  - out_valid=1 for this cycle only. Go to IDLE.
- Latency: out_valid rises CHANNELS+1 bclk cycles after the edge cycle. out holds its value until the next OUT.
- Accumulator width: BITSIZE+GAINBITS+clog2(CHANNELS)+1. No internal overflow is possible.
- Clamp range: [-2^(BITSIZE-1), 2^(BITSIZE-1)-1]. Behaviour per the optional feature.
- Config writes:
  - Accepted any cycle when cfg_addr < CHANNELS. Writes gain and mute of that channel together.
  - cfg_addr >= CHANNELS is ignored.
  - Writes during ACC/OUT affect the live regs only; they take effect from the next frame.
  - A write in the edge cycle E is not seen in frame E, because the snapshot takes pre-write values.
- Edge while busy: edge is ignored, overrun pulses 1 cycle, the current frame completes unaffected.
- Frame budget: CHANNELS+2 <= 64 is required; with legal parameters overrun never fires.
- busy = (state != IDLE).
- Reset mid-frame: abort immediately to reset values. No out_valid for the aborted frame.

Optional Feature:
MIXER_SAT_EN.
- Defined: the result is clamped to the signed BITSIZE range.
- Undefined: out takes the low BITSIZE bits of the shifted accumulator (wrap), and the clamp logic is not built.
- Latency is identical in both builds.

Test Plan:
- Defaults, in = {1000, 2000, -400, 0}, lrclk rise at cycle E -> out_valid at E+5 only, out=1300, busy high E+1..E+5.
- Channel 0 gain 64, channels 1-3 muted, in0=-1 -> out=-1 (floor of -64>>>7). Channel 0 gain 128 with in0=-32768 -> out=-32768.
- All gains 255, all inputs 32767 -> out=32767 with MIXER_SAT_EN. Without the macro, out=-1032 (wrap of 261112).
- Write channel 1 gain=0 at cycle E+2 during a frame -> the current frame still uses 0.5; the next frame excludes channel 1. cfg_addr=5 with CHANNELS=4 -> no register changes.
- Force an lrclk edge at E+3 (short frame) -> overrun pulse at the cycle it is detected, and the frame completes normally at E+5. Assert resetn=0 at E+2 -> no out_valid, out=0, gains back to 64.
- Release resetn with lrclk held high -> no frame starts until the next rising edge of lrclk.

Source files
------------

// File: rtl/mixer_sequencer.sv
// Time-multiplexed N-channel mixer: snapshot on lrclk rise, one MAC per bclk, scaled output.
// Optional build macro MIXER_SAT_EN: clamp to signed BITSIZE range (otherwise wrap).
module mixer_sequencer #(
  parameter int BITSIZE  = 16,
  parameter int CHANNELS = 4,
  parameter int GAINBITS = 8
) (
  input  logic                         bclk,
  input  logic                         resetn,
  input  logic                         lrclk,
  input  logic [CHANNELS*BITSIZE-1:0]  in_bus,
  input  logic                         cfg_we,
  input  logic [$clog2(CHANNELS)-1:0]  cfg_addr,
  input  logic [GAINBITS-1:0]          cfg_gain,
  input  logic                         cfg_mute,
  output logic [BITSIZE-1:0]           out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CW   = $clog2(CHANNELS);
  localparam int PW   = BITSIZE + GAINBITS + 1;
  localparam int ACCW = BITSIZE + GAINBITS + CW + 1;
  localparam logic [GAINBITS-1:0] GAIN_RST = {{(GAINBITS-1){1'b0}}, 1'b1} << (GAINBITS-2);
  localparam logic [CW:0]         CHAN_LIM = CHANNELS[CW:0];
  localparam logic [CW-1:0]       LAST_CH  = CW'(CHANNELS-1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                      state_q;
  logic                        lrclk_q;
  logic [GAINBITS-1:0]         live_gain_q [CHANNELS];
  logic [CHANNELS-1:0]         live_mute_q;
  logic [GAINBITS-1:0]         work_gain_q [CHANNELS];
  logic [CHANNELS-1:0]         work_mute_q;
  logic signed [BITSIZE-1:0]   sample_q [CHANNELS];
  logic signed [ACCW-1:0]      acc_q;
  logic [CW-1:0]               ch_q;
  logic [BITSIZE-1:0]          out_q;
  logic                        out_valid_q;
  logic                        busy_q;
  logic                        overrun_q;

  logic                        edge_d;
  logic signed [PW-1:0]        prod_d;
  logic signed [ACCW-1:0]      term_d;
  logic signed [ACCW-1:0]      acc_d;
  logic signed [ACCW-1:0]      shifted_d;
  logic [BITSIZE-1:0]          result_d;

`ifdef MIXER_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
`else
  logic                        unused_hi_d;
`endif

  // MAC step for the current channel and the scaled result of the final sum
  always_comb begin
    edge_d    = lrclk & ~lrclk_q;
    prod_d    = PW'(sample_q[ch_q]) * PW'($signed({1'b0, work_gain_q[ch_q]}));
    if (work_mute_q[ch_q]) begin
      term_d = {ACCW{1'b0}};
    end else begin
      term_d = ACCW'(prod_d);
    end
    acc_d     = acc_q + term_d;
    shifted_d = acc_d >>> (GAINBITS-1);
`ifdef MIXER_SAT_EN
    if (shifted_d > SAT_MAX) begin
      result_d = SAT_MAX[BITSIZE-1:0];
    end else if (shifted_d < SAT_MIN) begin
      result_d = SAT_MIN[BITSIZE-1:0];
    end else begin
      result_d = shifted_d[BITSIZE-1:0];
    end
`else
    result_d    = shifted_d[BITSIZE-1:0];
    unused_hi_d = ^shifted_d[ACCW-1:BITSIZE];
`endif
  end

  // Config registers, frame sequencer and registered outputs
  always_ff @(posedge bclk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      lrclk_q     <= 1'b1;
      live_mute_q <= {CHANNELS{1'b0}};
      work_mute_q <= {CHANNELS{1'b0}};
      acc_q       <= {ACCW{1'b0}};
      ch_q        <= {CW{1'b0}};
      out_q       <= {BITSIZE{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        live_gain_q[k] <= GAIN_RST;
        work_gain_q[k] <= GAIN_RST;
        sample_q[k]    <= {BITSIZE{1'b0}};
      end
    end else begin
      lrclk_q     <= lrclk;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (cfg_we && ({1'b0, cfg_addr} < CHAN_LIM)) begin
        live_gain_q[cfg_addr] <= cfg_gain;
        live_mute_q[cfg_addr] <= cfg_mute;
      end
      case (state_q)
        ST_IDLE: begin
          if (edge_d) begin
            // Snapshot reads pre-write live values, so a same-cycle write lands next frame
            for (int k = 0; k < CHANNELS; k++) begin
              sample_q[k]    <= in_bus[k*BITSIZE +: BITSIZE];
              work_gain_q[k] <= live_gain_q[k];
            end
            work_mute_q <= live_mute_q;
            acc_q       <= {ACCW{1'b0}};
            ch_q        <= {CW{1'b0}};
            busy_q      <= 1'b1;
            state_q     <= ST_ACC;
          end
        end
        ST_ACC: begin
          overrun_q <= edge_d;
          acc_q     <= acc_d;
          if (ch_q == LAST_CH) begin
            ch_q        <= {CW{1'b0}};
            out_q       <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            ch_q <= ch_q + CW'(1);
          end
        end
        ST_OUT: begin
          overrun_q <= edge_d;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mixer_sequencer.sv
// Directed self-checking bench for mixer_sequencer (4 channels, 16-bit, 8-bit gain).
module tb_mixer_sequencer;

  logic        bclk;
  logic        resetn;
  logic        lrclk;
  logic [63:0] in_bus;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_gain;
  logic        cfg_mute;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fails  = 0;

  mixer_sequencer #(.BITSIZE(16), .CHANNELS(4), .GAINBITS(8)) dut (
    .bclk(bclk), .resetn(resetn), .lrclk(lrclk), .in_bus(in_bus),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_gain(cfg_gain), .cfg_mute(cfg_mute),
    .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d);
    logic [15:0] wa, wb, wc, wd;
    wa = a[15:0]; wb = b[15:0]; wc = c[15:0]; wd = d[15:0];
    in_bus = {wd, wc, wb, wa};
  endtask

  task automatic write_cfg(input int ch, input int gain, input int mute);
    cfg_we   = 1'b1;
    cfg_addr = ch[1:0];
    cfg_gain = gain[7:0];
    cfg_mute = mute[0];
    tick();
    cfg_we = 1'b0;
  endtask

  // Starts a frame in the current cycle (E) and watches E+1..E+9.
  // wr_at >= 0: write wr_ch/wr_gain (unmuted) in cycle E+wr_at.
  // ovr_at >= 0: drop lrclk at E+1 and raise it again in cycle E+ovr_at.
  task automatic run_frame(input string tag, input int expv, input int wr_at,
                           input int wr_ch, input int wr_gain, input int ovr_at);
    int vcount, vfirst, vout, busy_bad, ocount, ofirst, c;
    vcount = 0; vfirst = -1; vout = 0; busy_bad = 0; ocount = 0; ofirst = -1;
    lrclk = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i == wr_at) begin
        cfg_we = 1'b1; cfg_addr = wr_ch[1:0]; cfg_gain = wr_gain[7:0]; cfg_mute = 1'b0;
      end else begin
        cfg_we = 1'b0;
      end
      if (ovr_at >= 0 && i == 1) lrclk = 1'b0;
      if (i == ovr_at) lrclk = 1'b1;
      tick();
      c = i + 1;
      if (out_valid) begin
        vcount++;
        if (vfirst < 0) vfirst = c;
        vout = int'($signed(out));
      end
      if (busy !== (c <= 5)) busy_bad++;
      if (overrun) begin
        ocount++;
        if (ofirst < 0) ofirst = c;
      end
    end
    cfg_we = 1'b0;
    lrclk  = 1'b0;
    tick();
    check_eq({tag, "_valid_count"}, vcount, 1);
    check_eq({tag, "_latency"}, vfirst, 5);
    check_eq({tag, "_out"}, vout, expv);
    check_eq({tag, "_out_hold"}, int'($signed(out)), expv);
    check_eq({tag, "_busy_window_errs"}, busy_bad, 0);
    if (ovr_at >= 0) begin
      check_eq({tag, "_overrun_count"}, ocount, 1);
      check_eq({tag, "_overrun_cycle"}, ofirst, ovr_at + 1);
    end else begin
      check_eq({tag, "_overrun_count"}, ocount, 0);
    end
  endtask

  initial begin
    int seen;
    int sat_exp;
    resetn = 1'b0; lrclk = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_gain = 8'd0; cfg_mute = 1'b0; in_bus = 64'd0;
    repeat (3) tick();
    check_eq("rst_out", int'(out), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_overrun", int'(overrun), 0);

    // Release reset with lrclk already high: no frame may start
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy || out_valid) seen++;
    end
    check_eq("rst_release_lrclk_high", seen, 0);
    lrclk = 1'b0;
    tick();

    // Default gains 0.5: (1000+2000-400)/2
    set_in(1000, 2000, -400, 0);
    run_frame("defaults", 1300, -1, 0, 0, -1);

    // Floor rounding of a negative result: -64 >>> 7 = -1
    write_cfg(0, 64, 0);
    write_cfg(1, 64, 1);
    write_cfg(2, 64, 1);
    write_cfg(3, 64, 1);
    set_in(-1, 1234, -5678, 32767);
    run_frame("floor_neg", -1, -1, 0, 0, -1);

    // Unity gain on full negative scale
    write_cfg(0, 128, 0);
    set_in(-32768, 1234, -5678, 32767);
    run_frame("unity_min", -32768, -1, 0, 0, -1);

    // All gains 255 on full positive scale: 261112 before clamp/wrap
    for (int k = 0; k < 4; k++) write_cfg(k, 255, 0);
    set_in(32767, 32767, 32767, 32767);
`ifdef MIXER_SAT_EN
    sat_exp = 32767;
`else
    sat_exp = -1032;
`endif
    run_frame("overflow", sat_exp, -1, 0, 0, -1);

    // Mid-frame write of ch1 gain=0 is seen only by the next frame
    for (int k = 0; k < 4; k++) write_cfg(k, 64, 0);
    set_in(1000, 2000, -400, 0);
    run_frame("midwrite_cur", 1300, 2, 1, 0, -1);
    // Write in the edge cycle (ch0 gain=0) is not seen by that frame
    run_frame("midwrite_next", 300, 0, 0, 0, -1);
    run_frame("edgewrite_next", -200, -1, 0, 0, -1);

    // Extra lrclk edge during ACC: overrun pulse, frame completes unaffected
    run_frame("overrun", -200, -1, 0, 0, 3);

    // Reset mid-frame: aborts, no valid, out and gains return to reset values
    lrclk = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check_eq("midrst_out", int'(out), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_valid", int'(out_valid), 0);
    lrclk = 1'b0;
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("midrst_no_valid", seen, 0);
    run_frame("after_rst", 1300, -1, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
